// File: rtl/param_counter.sv
// Parametrised up/down counter with wrap or saturate, sync clear, parallel load and carry pulse.
// Latency: cnt, cout and sat are registered and update one edge after en/clr/load are sampled.
// Backpressure: none; en gates stepping, and cout can drive a downstream instance's en.
//
// Ports: clk, rst (async, active high), en, clr, load, load_val[WIDTH], mode[2]
//        -> cnt[WIDTH], cout (one-cycle carry/borrow), sat (held at bound), zero (cnt == 0).
// Optional build macro CNT_PRESCALE_EN adds a PRESCALE-deep enable divider and a tick output.
module param_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX      = 15,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] cnt,
  output logic             cout,
  output logic             sat,
  output logic             zero
`ifdef CNT_PRESCALE_EN
  ,
  output logic             tick
`endif
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Reject configurations outside the supported range at elaboration time.
  if (WIDTH < 2 || WIDTH > 32 || MAX < 1 || PRESCALE < 1 ||
      longint'(MAX) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_param
    $error("param_counter: unsupported WIDTH/MAX/PRESCALE combination");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             sat_q, sat_d;
  logic             step;

`ifdef CNT_PRESCALE_EN
  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  // A counter step happens only on the enabled cycle that closes a prescale period;
  // clr/load take priority and also restart the period.
  assign step = en && !clr && !load && (pre_q == PRE_LAST);
  assign tick = step;

  always_comb begin
    pre_d = pre_q;
    if (clr || load) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign step = en;
`endif

  logic [WIDTH-1:0] bound;    // saturation bound for the current direction
  logic [WIDTH-1:0] ld_clamp;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;

  // Increment/decrement are only used when cnt is strictly inside the range,
  // so WIDTH-bit arithmetic never overflows.
  assign cnt_inc  = cnt_q + WIDTH'(1);
  assign cnt_dec  = cnt_q - WIDTH'(1);
  assign bound    = mode[0] ? '0 : MAX_V;
  assign ld_clamp = (load_val > MAX_V) ? MAX_V : load_val;

  always_comb begin
    cnt_d  = cnt_q;
    cout_d = 1'b0;
    sat_d  = 1'b0;
    if (clr) begin
      cnt_d = mode[0] ? MAX_V : '0;
    end else if (load) begin
      cnt_d = ld_clamp;
      sat_d = mode[1] && (ld_clamp == bound);
    end else begin
      if (step) begin
        unique case (mode)
          2'b00: begin
            if (cnt_q == MAX_V) begin
              cnt_d  = '0;
              cout_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          2'b01: begin
            if (cnt_q == '0) begin
              cnt_d  = MAX_V;
              cout_d = 1'b1;
            end else begin
              cnt_d = cnt_dec;
            end
          end
          2'b10: begin
            // Holding at MAX is not a step, so no repeated carry.
            if (cnt_q != MAX_V) begin
              cnt_d  = cnt_inc;
              cout_d = (cnt_inc == MAX_V);
            end
          end
          default: begin
            if (cnt_q != '0) begin
              cnt_d  = cnt_dec;
              cout_d = (cnt_dec == '0);
            end
          end
        endcase
      end
      // Without a step cnt_d equals cnt_q, so this also refreshes sat on idle cycles.
      sat_d = mode[1] && (cnt_d == bound);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      cout_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cout_q <= cout_d;
      sat_q  <= sat_d;
    end
  end

  assign cnt  = cnt_q;
  assign cout = cout_q;
  assign sat  = sat_q;
  assign zero = (cnt_q == '0);

endmodule
